// File: rtl/alu_flag_unit.sv
// alu_flag_unit: NZCV-producing execution stage with single-cycle ops and an iterative shift-add multiplier
module alu_flag_unit #(
   parameter int WIDTH = 16
) (
   input  logic             CLOCK_50,
   input  logic             RESET,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             set_flags,
   input  logic [3:0]       flags_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       NZCV,
   output logic             CNTRL_update_en
);
   localparam int SW = $clog2(WIDTH);
   localparam logic [SW:0] LAST = (SW+1)'(WIDTH);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;
   state_t state, state_nx;
   logic [3:0]       op_r, fin_r, nzcv;
   logic [WIDTH-1:0] a_r, b_r, acc, bb, res;
   logic [WIDTH:0]   sum, lsl_w, lsr_w;
   logic signed [WIDTH:0] asr_w;
   logic [SW-1:0]    sh;
   logic [SW:0]      cnt;
   logic             sf_r, is_sub, ci, av, c, v, legal;
   assign busy = state != S_IDLE;
   assign done = state == S_DONE;
   assign CNTRL_update_en = done & sf_r & legal;
   // state register; reset aborts any op in flight
   always_ff @(posedge CLOCK_50)
      state <= RESET ? S_IDLE : state_nx;
   // next-state: EXEC is one cycle, MUL runs WIDTH steps plus a write-back cycle
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = (op == 4'd10) ? S_MUL : S_EXEC;
         S_EXEC: state_nx = S_DONE;
         S_MUL:  if (cnt == LAST) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end
   // single-cycle datapath; subtraction is a + ~b + carry so C comes out as NOT borrow
   always_comb begin
      is_sub = op_r == 4'd2 || op_r == 4'd3 || op_r == 4'd11;
      bb = is_sub ? ~b_r : b_r;
      ci = (op_r == 4'd1 || op_r == 4'd3) ? fin_r[1] : is_sub;
      sum = {1'b0, a_r} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
      av = (a_r[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      sh = b_r[SW-1:0];
      lsl_w = {1'b0, a_r} << sh;
      lsr_w = {a_r, 1'b0} >> sh;
      asr_w = $signed({a_r, 1'b0}) >>> sh;
      res = '0;
      c = fin_r[1];
      v = fin_r[0];
      case (op_r)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd11: begin
            res = sum[WIDTH-1:0];
            c = sum[WIDTH];
            v = av;
         end
         4'd4: res = a_r & b_r;
         4'd5: res = a_r | b_r;
         4'd6: res = a_r ^ b_r;
         4'd7: begin
            res = lsl_w[WIDTH-1:0];
            c = (sh != '0) ? lsl_w[WIDTH] : fin_r[1];
         end
         4'd8: begin
            res = lsr_w[WIDTH:1];
            c = (sh != '0) ? lsr_w[0] : fin_r[1];
         end
         4'd9: begin
            res = asr_w[WIDTH:1];
            c = (sh != '0) ? asr_w[0] : fin_r[1];
         end
         4'd12: res = b_r;
         default: res = '0;
      endcase
      legal = op_r <= 4'd12;
      nzcv = legal ? {res[WIDTH-1], res == '0, c, v} : fin_r;
   end
   // operand latch, multiplier iteration and result/flag write-back on entry to DONE
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         op_r <= '0;
         a_r <= '0;
         b_r <= '0;
         fin_r <= '0;
         sf_r <= 1'b0;
         acc <= '0;
         cnt <= '0;
         result <= '0;
         NZCV <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_r <= op;
               a_r <= operand_a;
               b_r <= operand_b;
               fin_r <= flags_in;
               sf_r <= set_flags;
               acc <= '0;
               cnt <= '0;
            end
            S_EXEC: begin
               result <= res;
               NZCV <= nzcv;
            end
            S_MUL: if (cnt == LAST) begin
               result <= acc;
               NZCV <= {acc[WIDTH-1], acc == '0, fin_r[1:0]};
            end else begin
               acc <= acc + (b_r[0] ? a_r : '0);
               a_r <= a_r << 1;
               b_r <= b_r >> 1;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_flag_unit.sv
// tb_alu_flag_unit: directed checks of latency, result, NZCV and update strobe
module tb_alu_flag_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = '0;
   logic [15:0] operand_a = '0;
   logic [15:0] operand_b = '0;
   logic        set_flags = 1'b0;
   logic [3:0]  flags_in = '0;
   logic        busy, done, upd;
   logic [15:0] result;
   logic [3:0]  nzcv;
   int          passes = 0;
   int          total = 0;
   int          lat, dones;
   bit          busy_all, seen_done;
   alu_flag_unit #(.WIDTH(16)) dut (
      .CLOCK_50(clk), .RESET(rst), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .set_flags(set_flags),
      .flags_in(flags_in), .busy(busy), .done(done), .result(result),
      .NZCV(nzcv), .CNTRL_update_en(upd)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   // accept one op, then wait (bounded) until done; optionally keep poking start while busy
   task automatic go(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic sf, input logic [3:0] fi, input bit poke,
                     output int l, output bit ball);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; set_flags = sf; flags_in = fi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l = 1;
      ball = busy;
      while (done !== 1'b1 && l < 40) begin
         start = poke;
         if (poke) operand_a = 16'h0001;
         @(negedge clk);
         l++;
         ball &= busy;
      end
      start = 1'b0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_nzcv", nzcv, 0);
      chk("rst_upd", upd, 0);
      rst = 1'b0;
      go(4'd0, 16'h7FFF, 16'h0001, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("add_lat", lat, 2);
      chk("add_res", result, 16'h8000);
      chk("add_nzcv", nzcv, 4'b1001);
      chk("add_upd", upd, 1);
      @(negedge clk);
      chk("add_done_drop", done, 0);
      chk("add_upd_drop", upd, 0);
      chk("add_hold", result, 16'h8000);
      go(4'd2, 16'd5, 16'd5, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("sub_res", result, 16'h0000);
      chk("sub_nzcv", nzcv, 4'b0110);
      go(4'd11, 16'd3, 16'd5, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("cmp_res", result, 16'hFFFE);
      chk("cmp_nzcv", nzcv, 4'b1000);
      go(4'd7, 16'h8001, 16'd1, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("lsl_res", result, 16'h0002);
      chk("lsl_nzcv", nzcv, 4'b0010);
      go(4'd8, 16'h8001, 16'd0, 1'b1, 4'b0011, 1'b0, lat, busy_all);
      chk("lsr0_res", result, 16'h8001);
      chk("lsr0_nzcv", nzcv, 4'b1011);
      go(4'd9, 16'h8000, 16'd4, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("asr_res", result, 16'hF800);
      chk("asr_nzcv", nzcv, 4'b1000);
      go(4'd9, 16'h0018, 16'd4, 1'b1, 4'b0001, 1'b0, lat, busy_all);
      chk("asr_c_res", result, 16'h0001);
      chk("asr_c_nzcv", nzcv, 4'b0011);
      go(4'd10, 16'd300, 16'd300, 1'b1, 4'b0011, 1'b1, lat, busy_all);
      chk("mul_lat", lat, 18);
      chk("mul_busy", busy_all, 1);
      chk("mul_res", result, 16'h5F90);
      chk("mul_nzcv", nzcv, 4'b0011);
      chk("mul_upd", upd, 1);
      @(negedge clk);
      chk("mul_idle_after", busy, 0);
      go(4'd1, 16'hFFFF, 16'h0000, 1'b0, 4'b0010, 1'b0, lat, busy_all);
      chk("adc_res", result, 16'h0000);
      chk("adc_nzcv", nzcv, 4'b0110);
      chk("adc_upd", upd, 0);
      go(4'd14, 16'h1234, 16'h5678, 1'b1, 4'b1010, 1'b0, lat, busy_all);
      chk("ill_lat", lat, 2);
      chk("ill_res", result, 16'h0000);
      chk("ill_nzcv", nzcv, 4'b1010);
      chk("ill_upd", upd, 0);
      @(negedge clk);
      op = 4'd12; operand_b = 16'h1234; flags_in = 4'b0000; set_flags = 1'b1; start = 1'b1;
      dones = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      start = 1'b0;
      chk("held_start_dones", dones, 3);
      chk("mov_res", result, 16'h1234);
      chk("mov_nzcv", nzcv, 4'b0000);
      repeat (4) @(negedge clk);
      op = 4'd10; operand_a = 16'd7; operand_b = 16'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_done = 1'b0;
      for (int i = 2; i <= 7; i++) begin
         @(negedge clk);
         seen_done |= (done === 1'b1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      chk("abort_nzcv", nzcv, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen_done |= (done === 1'b1);
      end
      chk("abort_no_done", seen_done, 0);
      go(4'd0, 16'd1, 16'd2, 1'b1, 4'b0000, 1'b0, lat, busy_all);
      chk("post_lat", lat, 2);
      chk("post_res", result, 16'h0003);
      chk("post_nzcv", nzcv, 4'b0000);
      chk("post_upd", upd, 1);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Execution stage directly upstream of the flags register; produces the 4-bit NZCV vector and the CNTRL_update_en strobe that the flags register consumes.
- Accepts one operation per start/done handshake.
- Single-cycle ops: add/sub/logic/shift/move.
- MUL: iterative shift-add over WIDTH cycles.
- Current flags are fed back in so carry-in and the unchanged C/V bits can be passed through.

Parameters:
- WIDTH, 16, operand/result width; must be a power of two, >= 4.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- op  in  4  opcode, sampled at accept.
- operand_a  in  WIDTH  first operand, sampled at accept.
- operand_b  in  WIDTH  second operand or shift amount, sampled at accept.
- set_flags  in  1  request flag update, sampled at accept.
- flags_in  in  4  current NZCV from the flags register, sampled at accept.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result, NZCV and CNTRL_update_en are valid in that cycle.
- result  out  WIDTH  registered result; held until the next done.
- NZCV  out  4  computed flags {N,Z,C,V}; held until the next done.
- CNTRL_update_en  out  1  equals done AND latched set_flags AND legal op.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, CNTRL_update_en = 0.
  - result = 0, NZCV = 0.
  - MUL counter and accumulator = 0.
- Reset has priority over all other activity. Reset during EXEC or MUL aborts the op: no done pulse, outputs return to reset values the next cycle.
- States and transitions:
  - IDLE: start=1 latches inputs. If op=MUL go to MUL, else go to EXEC.
  - EXEC: compute the result, go to DONE.
  - MUL: one shift-add step per cycle for WIDTH cycles, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency (start accepted at edge t):
  - Non-MUL op: done high in cycle t+2.
  - MUL: done high in cycle t+WIDTH+2.
  - Maximum non-MUL throughput is one op every 3 cycles.
- Handshake:
  - start while busy=1 is ignored (not queued).
  - start held high continuously in IDLE is accepted again on the first IDLE cycle after done.
- Opcodes:
  - 0 ADD: a+b.
  - 1 ADC: a+b+Cin.
  - 2 SUB: a-b.
  - 3 SBC: a-b-(1-Cin).
  - 4 AND, 5 ORR, 6 EOR.
  - 7 LSL, 8 LSR, 9 ASR: shift amount = operand_b[log2(WIDTH)-1:0].
  - 10 MUL: low WIDTH bits of a*b.
  - 11 CMP: same as SUB; result output also written.
  - 12 MOV: result = b.
  - 13-15 illegal: result=0, NZCV=flags_in, CNTRL_update_en=0, done still pulses.
- Cin = flags_in[1]; Vin = flags_in[0].
- N and Z for all legal ops:
  - N = result[WIDTH-1].
  - Z = (result == 0).
- C and V by op class:
  - ADD/ADC: C = carry out of bit WIDTH-1. V = 1 when operand signs are equal and the result sign differs.
  - SUB/SBC/CMP: C = NOT borrow (ARM convention; SUB gives C=1 iff a >= b unsigned). V = 1 when operand signs differ and the result sign differs from a.
  - Logic/MOV/MUL: C = Cin, V = Vin.
  - Shifts: C = last bit shifted out; shift amount 0 gives C = Cin and result = a. V = Vin.
  - ASR fills with a[WIDTH-1].
- MUL arithmetic: WIDTH-bit accumulator, overflow discarded.
- Result and NZCV are updated only on the DONE transition; they are stable between done pulses.

Test Plan:
- Reset, then ADD a=16'h7FFF b=16'h0001 set_flags=1 -> done at t+2, result=16'h8000, NZCV=4'b1001, CNTRL_update_en=1 for one cycle.
- SUB a=5 b=5 set_flags=1 -> result=0, NZCV=4'b0110. Then CMP a=3 b=5 -> result=16'hFFFE, NZCV=4'b1000.
- LSL a=16'h8001 b=1 flags_in=4'b0000 -> result=16'h0002, NZCV=4'b0010. Then LSR b=0 flags_in=4'b0011 -> result=a, C=1, V=1.
- MUL a=300 b=300 -> busy high for the whole op, done exactly at t+18, result=16'h5F90 (90000 mod 65536), C/V equal to flags_in; start pulses during busy are ignored.
- ADC with Cin=1: a=16'hFFFF b=0 set_flags=0 -> result=0, NZCV=4'b0110, CNTRL_update_en=0. Then op=14 -> result=0, NZCV=flags_in, update_en=0.
- MUL started, RESET asserted at cycle t+8 -> no done pulse, busy=0 and outputs=0 the next cycle; a fresh ADD afterwards completes normally.
